// File: rtl/arrow_sequencer.sv
// rtl/arrow_sequencer.sv - rhythm game beat/arrow source with score, combo and lives keeping
//
// Generates the metronome beat and one pseudo-random arrow code per beat for the
// hit-collision checker, judges the checker's verdicts on the last cycle of each
// beat, and ends the game when lives run out.
//
// Ports:
//   clk, rst_n      system clock, asynchronous active-low reset
//   start           level; starts a game when sampled high in IDLE or OVER
//   correctHit      checker verdict: correct arrow hit this beat
//   incorrectHit    checker verdict: wrong, early or missing hit this beat
//   metronome_clk   high during the hit window of each beat
//   arrow           arrow code 10..19, 20 = rest
//   state           0 PLAY, 1 IDLE, 2 OVER
//   score, combo    hit count (sat. 9999), consecutive hits (sat. 255)
//   lives           remaining lives
//   game_over       high while in OVER
module arrow_sequencer #(
  parameter int          BEAT_CYCLES   = 50_000_000,
  parameter int          WINDOW_CYCLES = 25_000_000,
  parameter int          LIVES         = 3,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        correctHit,
  input  logic        incorrectHit,
  output logic        metronome_clk,
  output logic [4:0]  arrow,
  output logic [1:0]  state,
  output logic [13:0] score,
  output logic [7:0]  combo,
  output logic [1:0]  lives,
  output logic        game_over
);

  localparam int CW = $clog2(BEAT_CYCLES);
  localparam logic [CW-1:0] LAST_CYCLE = CW'(BEAT_CYCLES - 1);
  localparam logic [13:0] SCORE_MAX = 14'd9999;
  localparam logic [4:0]  ARROW_REST = 5'd20;

  typedef enum logic [1:0] {
    ST_PLAY = 2'd0,
    ST_IDLE = 2'd1,
    ST_OVER = 2'd2
  } state_t;

  state_t        st;
  logic [CW-1:0] counter;
  logic [15:0]   lfsr;
  logic [CW-1:0] counter_inc;
  logic [15:0]   lfsr_next;
  logic          miss;

  // Right-shifting Galois form; mask 0xB400 places taps 16,14,13,11.
  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
  endfunction

  // Fold the low nibble into 0..10; 10 maps to the rest code 20.
  function automatic logic [4:0] arrow_of(input logic [15:0] v);
    logic [3:0] idx;
    idx = v[3:0];
    if (idx >= 4'd11) idx = idx - 4'd11;
    return 5'd10 + {1'b0, idx};
  endfunction

  assign counter_inc = counter + 1'b1;
  assign lfsr_next   = lfsr_step(lfsr);
  // incorrectHit wins over correctHit; no verdict at all also counts as a miss.
  assign miss        = incorrectHit | ~correctHit;
  assign state       = st;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st            <= ST_IDLE;
      counter       <= '0;
      lfsr          <= LFSR_SEED;
      metronome_clk <= 1'b0;
      arrow         <= ARROW_REST;
      score         <= '0;
      combo         <= '0;
      lives         <= 2'(LIVES);
      game_over     <= 1'b0;
    end else begin
      case (st)
        ST_IDLE, ST_OVER: begin
          if (start) begin
            st            <= ST_PLAY;
            counter       <= '0;
            lfsr          <= lfsr_next;
            arrow         <= arrow_of(lfsr_next);
            metronome_clk <= 1'b1;
            score         <= '0;
            combo         <= '0;
            lives         <= 2'(LIVES);
            game_over     <= 1'b0;
          end
        end

        ST_PLAY: begin
          if (counter != LAST_CYCLE) begin
            counter       <= counter_inc;
            metronome_clk <= (int'(counter_inc) < WINDOW_CYCLES);
          end else begin
            counter <= '0;
            if (miss) begin
              combo <= '0;
              lives <= lives - 2'd1;
            end else begin
              if (score != SCORE_MAX) score <= score + 14'd1;
              if (combo != 8'd255)    combo <= combo + 8'd1;
            end

            if (miss && lives == 2'd1) begin
              // Fatal miss: park the beat outputs; LFSR is left where it is.
              st            <= ST_OVER;
              metronome_clk <= 1'b0;
              arrow         <= ARROW_REST;
              game_over     <= 1'b1;
            end else begin
              lfsr          <= lfsr_next;
              arrow         <= arrow_of(lfsr_next);
              metronome_clk <= 1'b1;
            end
          end
        end

        default: st <= ST_IDLE;
      endcase
    end
  end

endmodule
